// File: rtl/seg_pkg.sv
// Shared 7-segment constants and the nibble decode helper.
// Segment order is GFEDCBA, active-high.
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load-side bundle of the scanner: display data, load/ack handshake
// and the error override code.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);

    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;
    logic [NUM_DIGITS-1:0]   disp_blink;
    logic                    load;
    logic                    load_ack;
    logic [3:0]              err_code;

    modport master (
        output disp_data,
        output disp_dp,
        output disp_blank,
        output disp_blink,
        output load,
        output err_code,
        input  load_ack
    );

    modport slave (
        input  disp_data,
        input  disp_dp,
        input  disp_blank,
        input  disp_blink,
        input  load,
        input  err_code,
        output load_ack
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to 7-segment pattern.
// One instance serves the whole scanner on the muxed nibble.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multi-digit 7-segment scanner with frame-synchronous load and error override.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits in normal mode.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_ctrl_if.slave        bus,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         fcnt;
    logic                  blink_phase;
    logic [3:0]            err_r;
    logic                  pending;
    logic                  ack_r;
    logic [DW-1:0]         stg_data;
    logic [NUM_DIGITS-1:0] stg_dp;
    logic [NUM_DIGITS-1:0] stg_blank;
    logic [NUM_DIGITS-1:0] stg_blink;
    logic [DW-1:0]         sh_data;
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [NUM_DIGITS-1:0] sh_blank;
    logic [NUM_DIGITS-1:0] sh_blink;

    logic                  term;
    logic                  wrap;
    logic                  active;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            nib;
    logic [6:0]            dec;
    logic                  lit;
    logic                  dp_nxt;

    assign term   = (cnt == CW'(SCAN_DIV - 1));
    assign wrap   = term && (idx == IW'(NUM_DIGITS - 1));
    assign active = (cnt >= CW'(BLANK_CYC));

    assign bus.load_ack = ack_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (term) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Shadow only changes on the frame wrap so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r     <= '0;
            pending   <= 1'b0;
            ack_r     <= 1'b0;
            stg_data  <= '0;
            stg_dp    <= '0;
            stg_blank <= '1;
            stg_blink <= '0;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            sh_blink  <= '0;
        end else begin
            err_r <= bus.err_code;
            ack_r <= wrap && pending;
            if (wrap && pending) begin
                sh_data  <= stg_data;
                sh_dp    <= stg_dp;
                sh_blank <= stg_blank;
                sh_blink <= stg_blink;
            end
            if (bus.load) begin
                stg_data  <= bus.disp_data;
                stg_dp    <= bus.disp_dp;
                stg_blank <= bus.disp_blank;
                stg_blink <= bus.disp_blink;
            end
            if (bus.load) begin
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_run;

    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run = lz_run &&
                     (sh_blank[i] || sh_data[4*i +: 4] == 4'h0);
            lz[i]  = lz_run;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        nib    = sh_data[{idx, 2'b00} +: 4];
        lit    = 1'b0;
        dp_nxt = 1'b0;
        if (err_r != 4'h0) begin
            nib = (idx == '0) ? err_r : 4'hE;
            lit = ((idx == '0) || (idx == IW'(NUM_DIGITS - 1)))
                  && !blink_phase;
        end else begin
            lit    = !sh_blank[idx] && !(blink_phase && sh_blink[idx]);
            dp_nxt = lit && sh_dp[idx];
            lit    = lit && !lz[idx];
        end
    end

    seg_hex_decode u_dec (
        .nib (nib),
        .seg (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= SEG_OFF;
            dp_out     <= 1'b0;
            dig_sel    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (active) begin
                dig_sel <= NUM_DIGITS'(1) << idx;
                seg_out <= lit ? dec : SEG_OFF;
                dp_out  <= dp_nxt;
            end else begin
                dig_sel <= '0;
                seg_out <= SEG_OFF;
                dp_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at 4 digits, 4-cycle slots.
// Honours LEADING_ZERO_BLANK_EN in the leading-zero vector.
module tb_seg_scan_ctrl;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [ND-1:0] dig_sel;
    logic          frame_tick;

    int total = 0;
    int bad   = 0;
    int fr    = 0;
    int acks;
    int ticks;
    int nz;

    logic [6:0]    seg_c [ND];
    logic [ND-1:0] dp_c;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (4),
        .BLANK_CYC    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < lim);
        chk("tick_wait", 32'(frame_tick), 32'd1);
    endtask

    // Runs one frame starting just after a frame_tick sample.
    task automatic frame(input int lt1, input logic [15:0] ld1,
                         input int lt2, input logic [15:0] ld2);
        acks  = 0;
        ticks = 0;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (bus.load_ack) acks++;
            if (frame_tick) ticks++;
            if (t % 4 == 1)
                chk($sformatf("fr%0d_gap%0d", fr, t / 4),
                    32'({dig_sel, seg_out, dp_out}), 32'd0);
            if (t % 4 == 3) begin
                seg_c[t/4] = seg_out;
                dp_c[t/4]  = dp_out;
                chk($sformatf("fr%0d_sel%0d", fr, t / 4),
                    32'(dig_sel), 32'(1 << (t / 4)));
            end
            if (t == lt1) begin
                bus.disp_data = ld1;
                bus.load      = 1'b1;
            end else if (t == lt2) begin
                bus.disp_data = ld2;
                bus.load      = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
        end
        chk($sformatf("fr%0d_tick", fr), 32'(ticks), 32'd1);
        chk($sformatf("fr%0d_tickend", fr), 32'(frame_tick), 32'd1);
        fr++;
    endtask

    task automatic chk_frame(input string tag, input logic [27:0] es,
                             input logic [3:0] ed, input int ea);
        chk({tag, "_seg"},
            32'({seg_c[3], seg_c[2], seg_c[1], seg_c[0]}), 32'(es));
        chk({tag, "_dp"}, 32'(dp_c), 32'(ed));
        chk({tag, "_ack"}, 32'(acks), 32'(ea));
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.disp_data  = '0;
        bus.disp_dp    = '0;
        bus.disp_blank = '0;
        bus.disp_blink = '0;
        bus.load       = 1'b0;
        bus.err_code   = '0;
        repeat (3) @(negedge clk);
        chk("reset",
            32'({seg_out, dp_out, dig_sel, frame_tick, bus.load_ack}),
            32'd0);
        rst_n = 1'b1;
        wait_tick(40);
        fr = 1;

        // all blanked after reset
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("blank", 28'h0, 4'b0000, 0);

        // mid-frame load, commit on wrap
        bus.disp_dp = 4'b0100;
        frame(5, 16'h1234, 0, 16'h0);
        chk_frame("ld_old", 28'h0, 4'b0000, 1);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("ld_1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 0);

        // double load in one frame
        frame(3, 16'h1111, 7, 16'h2222);
        chk_frame("dbl_old", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 1);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("dbl_2222", {4{7'h5B}}, 4'b0100, 0);

        // blink on digit 0: frames 7,10 dark, 8,9 lit
        bus.disp_blink = 4'b0001;
        frame(2, 16'h2222, 0, 16'h0);
        chk_frame("bl_ld", {4{7'h5B}}, 4'b0100, 1);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("bl_f7", {7'h5B, 7'h5B, 7'h5B, 7'h00}, 4'b0100, 0);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("bl_f8", {4{7'h5B}}, 4'b0100, 0);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("bl_f9", {4{7'h5B}}, 4'b0100, 0);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("bl_f10", {7'h5B, 7'h5B, 7'h5B, 7'h00}, 4'b0100, 0);

        // error override, frame 11 dark phase, 12 lit
        bus.err_code = 4'h5;
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("err_f11", 28'h0, 4'b0000, 0);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("err_f12", {7'h79, 7'h00, 7'h00, 7'h6D}, 4'b0000, 0);
        bus.err_code = 4'h0;
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("err_off", {4{7'h5B}}, 4'b0100, 0);

        // leading zeros
        bus.disp_blink = 4'b0000;
        bus.disp_dp    = 4'b1000;
        frame(2, 16'h0070, 0, 16'h0);
        chk_frame("lz_old", {7'h5B, 7'h5B, 7'h5B, 7'h00}, 4'b0100, 1);
        frame(0, 16'h0, 0, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
        chk_frame("lz", {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b1000, 0);
`else
        chk_frame("lz", {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b1000, 0);
`endif

        // load coincident with the wrap
        bus.disp_dp = 4'b0000;
        frame(5, 16'h4444, 15, 16'h8888);
        chk(" co_ack0", 32'(acks), 32'd1);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("co_4444", {4{7'h66}}, 4'b0000, 1);
        frame(0, 16'h0, 0, 16'h0);
        chk_frame("co_8888", {4{7'h7F}}, 4'b0000, 0);

        // reset with a load pending
        repeat (2) @(negedge clk);
        bus.disp_data = 16'h9999;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        chk("pre_rst_sel", 32'(dig_sel), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async",
            32'({seg_out, dp_out, dig_sel, frame_tick, bus.load_ack}),
            32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        acks  = 0;
        ticks = 0;
        nz    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.load_ack) acks++;
            if (frame_tick) ticks++;
            if (seg_out != 7'h0) nz++;
        end
        chk("rst_ack", 32'(acks), 32'd0);
        chk("rst_seg", 32'(nz), 32'd0);
        chk("rst_ticks", 32'(ticks), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
